// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction queue between icache fetch and decode: 2-wide enqueue, up to 2-wide dequeue, circular register array.
// Optional IFB_STALL_CNT_EN adds stall_cycles, a saturating count of cycles where fetch offered a packet that was refused.
module inst_fetch_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_pc2,
    input  logic [31:0]      in_inst1,
    input  logic [31:0]      in_inst2,
    input  logic             in_exc1,
    input  logic             in_exc2,
    input  logic [6:0]       in_cause1,
    input  logic [6:0]       in_cause2,
    input  logic [31:0]      in_pred_addr,
    input  logic [1:0]       in_pred_taken,
    output logic             in_ready,
    input  logic [1:0]       dec_pop,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_pc2,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_inst2,
    output logic             out_exc1,
    output logic             out_exc2,
    output logic [6:0]       out_cause1,
    output logic [6:0]       out_cause2,
    output logic [31:0]      out_pred_addr1,
    output logic [31:0]      out_pred_addr2,
    output logic             out_pred_taken1,
    output logic             out_pred_taken2,
`ifdef IFB_STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  cause;
        logic [31:0] pred_addr;
        logic        pred_taken;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   head_p1;
    logic [PTR_W-1:0]   tail_p1;
    logic               enq;
    logic [1:0]         pop;
    entry_t             wr1;
    entry_t             wr2;
    entry_t             rd1;
    entry_t             rd2;

    assign head_p1  = head + PTR_W'(1);
    assign tail_p1  = tail + PTR_W'(1);
    // Ready looks only at registered occupancy, so fetch never sees a path through dec_pop.
    assign in_ready = (count <= (PTR_W+1)'(DEPTH - 2));
    assign enq      = in_valid & in_ready;

    always_comb begin
        pop = dec_pop[1] ? 2'd2 : dec_pop;
        if ((PTR_W+1)'(pop) > count) begin
            pop = count[1:0];
        end
    end

    assign wr1 = '{pc: in_pc1, inst: in_inst1, exc: in_exc1, cause: in_cause1,
                   pred_addr: in_pred_addr, pred_taken: in_pred_taken[0]};
    assign wr2 = '{pc: in_pc2, inst: in_inst2, exc: in_exc2, cause: in_cause2,
                   pred_addr: in_pred_addr, pred_taken: in_pred_taken[1]};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(2);
            end
            head  <= head + PTR_W'(pop);
            count <= count + (enq ? (PTR_W+1)'(2) : '0) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && enq) begin
            mem[tail]    <= wr1;
            mem[tail_p1] <= wr2;
        end
    end

    assign out_valid1 = (count != '0);
    assign out_valid2 = (count >= (PTR_W+1)'(2));
    assign rd1 = out_valid1 ? mem[head]    : '0;
    assign rd2 = out_valid2 ? mem[head_p1] : '0;

    assign out_pc1         = rd1.pc;
    assign out_inst1       = rd1.inst;
    assign out_exc1        = rd1.exc;
    assign out_cause1      = rd1.cause;
    assign out_pred_addr1  = rd1.pred_addr;
    assign out_pred_taken1 = rd1.pred_taken;
    assign out_pc2         = rd2.pc;
    assign out_inst2       = rd2.inst;
    assign out_exc2        = rd2.exc;
    assign out_cause2      = rd2.cause;
    assign out_pred_addr2  = rd2.pred_addr;
    assign out_pred_taken2 = rd2.pred_taken;

`ifdef IFB_STALL_CNT_EN
    // Survives flush on purpose: it measures fetch starvation over the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized plus directed bench for inst_fetch_buffer; a queue-based reference model is checked every cycle.
module tb_inst_fetch_buffer;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  cause;
        logic [31:0] pred_addr;
        logic        pred_taken;
    } ent_t;

    logic clk = 0, rst = 1, flush = 0, in_valid = 0;
    logic [31:0] in_pc1 = 0, in_pc2 = 0, in_inst1 = 0, in_inst2 = 0, in_pred_addr = 0;
    logic in_exc1 = 0, in_exc2 = 0;
    logic [6:0] in_cause1 = 0, in_cause2 = 0;
    logic [1:0] in_pred_taken = 0, dec_pop = 0;
    logic in_ready, out_valid1, out_valid2, out_exc1, out_exc2, out_pred_taken1, out_pred_taken2;
    logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2, out_pred_addr1, out_pred_addr2;
    logic [6:0] out_cause1, out_cause2;
    logic [PTR_W:0] count;
`ifdef IFB_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_exp = 0;
`endif

    int checks = 0, failures = 0;
    bit started = 0;
    ent_t q[$];

    inst_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_pc1(in_pc1), .in_pc2(in_pc2), .in_inst1(in_inst1), .in_inst2(in_inst2),
        .in_exc1(in_exc1), .in_exc2(in_exc2), .in_cause1(in_cause1), .in_cause2(in_cause2),
        .in_pred_addr(in_pred_addr), .in_pred_taken(in_pred_taken), .in_ready(in_ready),
        .dec_pop(dec_pop), .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_pc1(out_pc1), .out_pc2(out_pc2), .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_exc1(out_exc1), .out_exc2(out_exc2), .out_cause1(out_cause1), .out_cause2(out_cause2),
        .out_pred_addr1(out_pred_addr1), .out_pred_addr2(out_pred_addr2),
        .out_pred_taken1(out_pred_taken1), .out_pred_taken2(out_pred_taken2),
`ifdef IFB_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compares outputs to the model, then applies this cycle's inputs to the model.
    always @(negedge clk) begin : monitor
        int n;
        int p;
        ent_t x1;
        ent_t x2;
        if (started) begin
            n  = q.size();
            x1 = (n >= 1) ? q[0] : '0;
            x2 = (n >= 2) ? q[1] : '0;
            chk("count", 128'(count), 128'(n));
            chk("in_ready", 128'(in_ready), 128'(n <= DEPTH - 2));
            chk("out_valid1", 128'(out_valid1), 128'(n >= 1));
            chk("out_valid2", 128'(out_valid2), 128'(n >= 2));
            chk("slot1", 128'({out_pc1, out_inst1, out_exc1, out_cause1, out_pred_addr1, out_pred_taken1}), 128'(x1));
            chk("slot2", 128'({out_pc2, out_inst2, out_exc2, out_cause2, out_pred_addr2, out_pred_taken2}), 128'(x2));
`ifdef IFB_STALL_CNT_EN
            chk("stall_cycles", 128'(stall_cycles), 128'(stall_exp));
            if (rst) stall_exp = 0;
            else if (in_valid && n > DEPTH - 2 && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
`endif
            if (rst || flush) begin
                q.delete();
            end else begin
                p = (dec_pop == 2'd3) ? 2 : int'(dec_pop);
                if (p > n) p = n;
                repeat (p) void'(q.pop_front());
                if (in_valid && n <= DEPTH - 2) begin
                    q.push_back('{pc: in_pc1, inst: in_inst1, exc: in_exc1, cause: in_cause1,
                                  pred_addr: in_pred_addr, pred_taken: in_pred_taken[0]});
                    q.push_back('{pc: in_pc2, inst: in_inst2, exc: in_exc2, cause: in_cause2,
                                  pred_addr: in_pred_addr, pred_taken: in_pred_taken[1]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0;
        dec_pop  = 0;
        flush    = 0;
    endtask

    task automatic drive_pkt(input logic [31:0] pc);
        in_valid      = 1;
        in_pc1        = pc;
        in_pc2        = pc + 32'd4;
        in_inst1      = $urandom;
        in_inst2      = $urandom;
        in_exc1       = 1'($urandom_range(0, 1));
        in_exc2       = 1'($urandom_range(0, 1));
        in_cause1     = 7'($urandom_range(0, 127));
        in_cause2     = 7'($urandom_range(0, 127));
        in_pred_addr  = $urandom;
        in_pred_taken = 2'($urandom_range(0, 3));
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    initial begin : stim
        logic [31:0] pc;
        logic [31:0] pc0;
        bit held;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        started = 1;

        // Reset state
        tick();
        chk("t1_count", 128'(count), 128'(0));
        chk("t1_in_ready", 128'(in_ready), 128'(1));
        chk("t1_out_valid1", 128'(out_valid1), 128'(0));
        chk("t1_out_inst1", 128'(out_inst1), 128'(0));

        // Single packet, one-cycle visibility
        drive_pkt(32'h1c00_0000);
        in_inst1 = 32'h0280_0000;
        tick();
        idle();
        chk("t2_count", 128'(count), 128'(2));
        chk("t2_out_pc1", 128'(out_pc1), 128'(32'h1c00_0000));
        chk("t2_out_pc2", 128'(out_pc2), 128'(32'h1c00_0004));
        chk("t2_out_inst1", 128'(out_inst1), 128'(32'h0280_0000));
        dec_pop = 2;
        tick();
        idle();

        // Fill to full, hold 9th packet, pop without same-cycle credit
        pc = 32'h1c00_1000;
        for (int i = 0; i < 8; i++) begin
            drive_pkt(pc);
            pc += 8;
            tick();
        end
        drive_pkt(pc);
        pc += 8;
        repeat (3) tick();
        chk("t3_full_count", 128'(count), 128'(16));
        chk("t3_full_ready", 128'(in_ready), 128'(0));
        dec_pop = 2;
        tick();
        dec_pop = 0;
        chk("t3_after_pop", 128'(count), 128'(14));
        tick();
        idle();
        chk("t3_refill", 128'(count), 128'(16));
        dec_pop = 2;
        repeat (8) tick();
        idle();

        // Pointer wrap across index 15 -> 0
        do_flush();
        pc0 = 32'h2000_0000;
        pc  = pc0;
        for (int i = 0; i < 8; i++) begin
            drive_pkt(pc);
            pc += 8;
            tick();
        end
        idle();
        dec_pop = 2;
        repeat (7) tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            drive_pkt(pc);
            pc += 8;
            tick();
        end
        idle();
        dec_pop = 1;
        for (int k = 0; k < 10; k++) begin
            chk("t4_wrap_pc", 128'(out_pc1), 128'(pc0 + 32'd56 + 32'(4 * k)));
            tick();
        end
        idle();

        // Pop clipping and simultaneous enq/pop
        do_flush();
        drive_pkt(pc);
        pc += 8;
        tick();
        idle();
        dec_pop = 1;
        tick();
        dec_pop = 2;
        tick();
        idle();
        chk("t5_clip", 128'(count), 128'(0));
        for (int i = 0; i < 2; i++) begin
            drive_pkt(pc);
            pc += 8;
            tick();
        end
        idle();
        dec_pop = 1;
        tick();
        chk("t5_count3", 128'(count), 128'(3));
        drive_pkt(pc);
        pc += 8;
        tick();
        idle();
        chk("t5_count4", 128'(count), 128'(4));

        // Flush beats simultaneous enq/pop
        drive_pkt(pc);
        pc += 8;
        tick();
        chk("t6_count6", 128'(count), 128'(6));
        drive_pkt(pc);
        dec_pop = 2;
        flush   = 1;
        tick();
        idle();
        chk("t6_count0", 128'(count), 128'(0));
        chk("t6_valid1", 128'(out_valid1), 128'(0));

        // Randomized traffic; a refused packet is held until accepted
        held = 0;
        for (int c = 0; c < 800; c++) begin
            if (!held) begin
                if ($urandom_range(0, 3) != 0) begin
                    drive_pkt(pc);
                    pc += 8;
                end else begin
                    in_valid = 0;
                end
            end
            dec_pop = 2'($urandom_range(0, 3));
            if (c < 200 && dec_pop != 0) dec_pop = 2'($urandom_range(0, 1));
            flush = ($urandom_range(0, 59) == 0);
            held  = in_valid && !in_ready && !flush;
            tick();
        end
        idle();
        repeat (2) tick();
        started = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
